// File: rtl/seq_mul_add_pkg.sv
// seq_mul_add_pkg: shared state enumeration and default operand width for the repeated-addition multiplier
package seq_mul_add_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DONE} state_t;
endpackage

// File: rtl/seq_mul_add_if.sv
// seq_mul_add_if: operand/result bus (start, data_in from master; product, done from slave)
interface seq_mul_add_if import seq_mul_add_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic done;
  modport master (output start, data_in, input product, done);
  modport slave (input start, data_in, output product, done);
endinterface

// File: rtl/seq_mul_add_ctrl.sv
// seq_mul_ctrl: multiplier FSM (in clk, rst_n, start, eqz; out lda, ldb, ldp, clrp, decb, registered done)
module seq_mul_ctrl import seq_mul_add_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic eqz,
  output logic lda,
  output logic ldb,
  output logic ldp,
  output logic clrp,
  output logic decb,
  output logic done
);
  state_t state_q;
  logic done_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:   state_q <= start ? LOAD_A : IDLE;
        LOAD_A: state_q <= LOAD_B;
        LOAD_B: state_q <= RUN;
        RUN:    if (eqz) begin
                  state_q <= DONE;
                  done_q <= 1'b1;
                end
        DONE:   if (!start) begin
                  state_q <= IDLE;
                  done_q <= 1'b0;
                end
        default: begin
          state_q <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end
  assign lda  = state_q == LOAD_A;
  assign ldb  = state_q == LOAD_B;
  assign clrp = state_q == LOAD_B;
  assign ldp  = state_q == RUN && !eqz;
  assign decb = state_q == RUN && !eqz;
  assign done = done_q;
endmodule

// File: rtl/seq_mul_add.sv
// seq_mul_add: unsigned A*B by repeated addition (clk, rst_n, bus slave: start/data_in in, product/done out)
module seq_mul_add import seq_mul_add_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic clk,
  input logic rst_n,
  seq_mul_add_if.slave bus
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic lda, ldb, ldp, clrp, decb, eqz, done;
  seq_mul_ctrl u_ctrl (
    .clk(clk), .rst_n(rst_n), .start(bus.start), .eqz(eqz),
    .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb), .done(done)
  );
  assign eqz = b_q == '0;
  always_comb begin
    a_d = lda ? bus.data_in : a_q;
    b_d = ldb ? bus.data_in : decb ? b_q - WIDTH'(1) : b_q;
    p_d = clrp ? '0 : ldp ? p_q + a_q : p_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end
  assign bus.product = p_q;
  assign bus.done = done;
endmodule

// File: tb/tb_seq_mul_add.sv
// tb_seq_mul_add: randomized and directed checks of seq_mul_add against a behavioural timing/arithmetic model
module tb_seq_mul_add;
  logic clk, rst_n, chk_en;
  int checks = 0, errors = 0;
  seq_mul_add_if #(.WIDTH(16)) bus();
  seq_mul_add #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int m_t = -1;
  logic m_done = 0;
  logic [15:0] m_a = 0, m_b = 0, m_p;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = -1;
      m_done = 0;
    end else if (m_done) m_done = bus.start;
    else if (m_t < 0) begin
      if (bus.start) m_t = 0;
    end else begin
      m_t++;
      if (m_t == 1) m_a = bus.data_in;
      if (m_t == 2) m_b = bus.data_in;
      if (m_t > 2 && m_t == int'(m_b) + 3) begin
        m_done = 1;
        m_t = -1;
      end
    end
  end
  assign m_p = m_a * m_b;
  always @(negedge clk) if (chk_en) begin
    chk("done_model", 32'(bus.done), 32'(m_done));
    if (m_done) chk("product_model", 32'(bus.product), 32'(m_p));
  end
  task automatic op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk); bus.start = 1; bus.data_in = 16'($urandom);
    @(negedge clk); bus.data_in = a;
    @(negedge clk); bus.data_in = b;
    @(negedge clk); bus.data_in = 16'($urandom);
    lat = 2;
    while (!bus.done && lat < 2000) begin
      @(negedge clk);
      lat++;
      bus.data_in = 16'($urandom);
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic release_start();
    @(negedge clk); bus.start = 0;
    @(negedge clk); chk("drop_start_idle", 32'(bus.done), 0);
  endtask
  int lat;
  logic [15:0] ra, rb;
  initial begin
    chk_en = 0;
    rst_n = 0;
    bus.start = 0;
    bus.data_in = 0;
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_product", 32'(bus.product), 0);
    chk_en = 1;
    rst_n = 1;
    op(17, 5, lat);
    chk("lat_17x5", lat, 8);
    chk("prod_17x5", 32'(bus.product), 85);
    repeat (3) begin
      @(negedge clk);
      chk("hold_prod", 32'(bus.product), 85);
      chk("hold_done", 32'(bus.done), 1);
    end
    release_start();
    op(9, 0, lat);
    chk("lat_9x0", lat, 3);
    chk("prod_9x0", 32'(bus.product), 0);
    release_start();
    op(0, 7, lat);
    chk("lat_0x7", lat, 10);
    chk("prod_0x7", 32'(bus.product), 0);
    release_start();
    op(300, 300, lat);
    chk("lat_300x300", lat, 303);
    chk("prod_300x300", 32'(bus.product), 24464);
    release_start();
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.data_in = 5;
    @(negedge clk); bus.data_in = 50;
    repeat (8) @(negedge clk);
    rst_n = 0;
    bus.start = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrun_rst_done", 32'(bus.done), 0);
    chk("midrun_rst_product", 32'(bus.product), 0);
    repeat (3) @(negedge clk);
    chk("post_rst_wait", 32'(bus.done), 0);
    op(6, 7, lat);
    chk("lat_6x7", lat, 10);
    chk("prod_6x7", 32'(bus.product), 42);
    release_start();
    repeat (10) begin
      @(negedge clk);
      chk("idle_done", 32'(bus.done), 0);
      chk("idle_product", 32'(bus.product), 42);
    end
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 40));
      op(ra, rb, lat);
      chk("rand_lat", lat, 3 + int'(rb));
      chk("rand_prod", 32'(bus.product), 32'(16'(ra * rb)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_start();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
